// File: rtl/mioc_reset_seq.sv
// mioc_reset_seq: reset sequencer ahead of the MIOC reset outputs.
// Merges power-on reset, the debounced ADAM pushbutton and the ColecoVision
// game reset into stretched, registered RST_N / CPRST_N / NETRST_N and
// records which source started the most recent reset sequence.
module mioc_reset_seq #(
  parameter int DEBOUNCE_CYCLES = 16384,
  parameter int RST_STRETCH     = 1024,
  parameter int NET_STRETCH     = 4096,
  parameter int CNT_W           = 16
) (
  input  logic       B_PHI,
  input  logic       POR_N,
  input  logic       PBRST_N,
  input  logic       N_CVRST,
  output logic       RST_N,
  output logic       CPRST_N,
  output logic       NETRST_N,
  output logic [1:0] RST_CAUSE
);

  // Sequencer states
  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_ASSERT   = 2'd1;
  localparam logic [1:0] ST_WAIT_REL = 2'd2;
  localparam logic [1:0] ST_NET      = 2'd3;

  // Reset cause encodings (2'b00 is never produced)
  localparam logic [1:0] CAUSE_POR = 2'b01;
  localparam logic [1:0] CAUSE_PB  = 2'b10;
  localparam logic [1:0] CAUSE_CV  = 2'b11;

  // Terminal counts: a phase of N cycles ends when the counter reads N-1
  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_STRETCH - 1);
  localparam logic [CNT_W-1:0] NET_LAST = CNT_W'(NET_STRETCH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  // Saturating increment: counters stick at all-ones instead of wrapping
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (v == CNT_MAX) begin
      r = v;
    end else begin
      r = v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

  // Synchronisers (idle high)
  logic pb_s1_q, pb_s2_q;
  logic cv_s1_q, cv_s2_q;

  // Debouncer
  logic             pb_db_q, pb_db_d;
  logic [CNT_W-1:0] db_cnt_q, db_cnt_d;

  // Sequencer
  logic [1:0]       state_q, state_d;
  logic [1:0]       cause_q, cause_d;
  logic [CNT_W-1:0] seq_cnt_q, seq_cnt_d;
  logic             net_hold_q, net_hold_d;

  // Registered outputs
  logic rst_n_q, rst_n_d;
  logic cprst_n_q, cprst_n_d;
  logic netrst_n_q, netrst_n_d;

  logic       pb_req_s;
  logic       cv_req_s;
  logic       any_req_s;
  logic [1:0] rel_state_s;

  assign pb_req_s  = ~pb_db_q;
  assign cv_req_s  = ~cv_s2_q;
  assign any_req_s = pb_req_s | cv_req_s;

  // A game-only sequence skips the AdamNET tail unless it interrupted one
  assign rel_state_s = ((cause_q != CAUSE_CV) || net_hold_q) ? ST_NET : ST_RUN;

  // Two-flop synchronisers for the asynchronous reset requests
  always_ff @(posedge B_PHI or negedge POR_N) begin
    if (!POR_N) begin
      pb_s1_q <= 1'b1;
      pb_s2_q <= 1'b1;
      cv_s1_q <= 1'b1;
      cv_s2_q <= 1'b1;
    end else begin
      pb_s1_q <= PBRST_N;
      pb_s2_q <= pb_s1_q;
      cv_s1_q <= N_CVRST;
      cv_s2_q <= cv_s1_q;
    end
  end

  // Pushbutton debounce: accept a new level only after a full run of differing samples
  always_comb begin
    pb_db_d  = pb_db_q;
    db_cnt_d = db_cnt_q;
    if (pb_s2_q == pb_db_q) begin
      db_cnt_d = CNT_ZERO;
    end else if (db_cnt_q == DB_LAST) begin
      pb_db_d  = pb_s2_q;
      db_cnt_d = CNT_ZERO;
    end else begin
      db_cnt_d = sat_inc(db_cnt_q);
    end
  end

  // Debounce state registers
  always_ff @(posedge B_PHI or negedge POR_N) begin
    if (!POR_N) begin
      pb_db_q  <= 1'b1;
      db_cnt_q <= CNT_ZERO;
    end else begin
      pb_db_q  <= pb_db_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  // Sequencer next state, cause tracking and phase counter
  always_comb begin
    state_d    = state_q;
    cause_d    = cause_q;
    seq_cnt_d  = seq_cnt_q;
    net_hold_d = net_hold_q;
    case (state_q)
      ST_RUN: begin
        seq_cnt_d = CNT_ZERO;
        if (pb_req_s) begin
          state_d    = ST_ASSERT;
          cause_d    = CAUSE_PB;
          net_hold_d = 1'b0;
        end else if (cv_req_s) begin
          state_d    = ST_ASSERT;
          cause_d    = CAUSE_CV;
          net_hold_d = 1'b0;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_ASSERT: begin
        if ((cause_q == CAUSE_CV) && pb_req_s) begin
          // Pushbutton upgrades a game reset and restarts the stretch
          cause_d    = CAUSE_PB;
          seq_cnt_d  = CNT_ZERO;
          net_hold_d = 1'b0;
        end else if (seq_cnt_q == RST_LAST) begin
          seq_cnt_d = CNT_ZERO;
          if (any_req_s) begin
            state_d = ST_WAIT_REL;
          end else begin
            state_d = rel_state_s;
          end
        end else begin
          seq_cnt_d = sat_inc(seq_cnt_q);
        end
      end
      ST_WAIT_REL: begin
        seq_cnt_d = CNT_ZERO;
        if ((cause_q == CAUSE_CV) && pb_req_s) begin
          state_d    = ST_ASSERT;
          cause_d    = CAUSE_PB;
          net_hold_d = 1'b0;
        end else if (!any_req_s) begin
          state_d = rel_state_s;
        end else begin
          state_d = ST_WAIT_REL;
        end
      end
      ST_NET: begin
        if (pb_req_s) begin
          state_d    = ST_ASSERT;
          cause_d    = CAUSE_PB;
          seq_cnt_d  = CNT_ZERO;
          net_hold_d = 1'b0;
        end else if (cv_req_s) begin
          // Game reset mid-tail: AdamNET stays held through the new sequence
          state_d    = ST_ASSERT;
          cause_d    = CAUSE_CV;
          seq_cnt_d  = CNT_ZERO;
          net_hold_d = 1'b1;
        end else if (seq_cnt_q == NET_LAST) begin
          state_d    = ST_RUN;
          seq_cnt_d  = CNT_ZERO;
          net_hold_d = 1'b0;
        end else begin
          seq_cnt_d = sat_inc(seq_cnt_q);
        end
      end
      default: begin
        state_d    = ST_ASSERT;
        cause_d    = CAUSE_POR;
        seq_cnt_d  = CNT_ZERO;
        net_hold_d = 1'b0;
      end
    endcase
  end

  // Output levels derived from the next state so they switch with the transition
  always_comb begin
    rst_n_d    = 1'b0;
    cprst_n_d  = 1'b0;
    netrst_n_d = 1'b0;
    case (state_d)
      ST_RUN: begin
        rst_n_d    = 1'b1;
        cprst_n_d  = 1'b1;
        netrst_n_d = 1'b1;
      end
      ST_ASSERT, ST_WAIT_REL: begin
        rst_n_d    = 1'b0;
        cprst_n_d  = (cause_d == CAUSE_CV);
        netrst_n_d = (cause_d == CAUSE_CV) && !net_hold_d;
      end
      ST_NET: begin
        rst_n_d    = 1'b1;
        cprst_n_d  = 1'b1;
        netrst_n_d = 1'b0;
      end
      default: begin
        rst_n_d    = 1'b0;
        cprst_n_d  = 1'b0;
        netrst_n_d = 1'b0;
      end
    endcase
  end

  // Sequencer and output registers; power-on reset forces a POR sequence
  always_ff @(posedge B_PHI or negedge POR_N) begin
    if (!POR_N) begin
      state_q    <= ST_ASSERT;
      cause_q    <= CAUSE_POR;
      seq_cnt_q  <= CNT_ZERO;
      net_hold_q <= 1'b0;
      rst_n_q    <= 1'b0;
      cprst_n_q  <= 1'b0;
      netrst_n_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cause_q    <= cause_d;
      seq_cnt_q  <= seq_cnt_d;
      net_hold_q <= net_hold_d;
      rst_n_q    <= rst_n_d;
      cprst_n_q  <= cprst_n_d;
      netrst_n_q <= netrst_n_d;
    end
  end

  assign RST_N     = rst_n_q;
  assign CPRST_N   = cprst_n_q;
  assign NETRST_N  = netrst_n_q;
  assign RST_CAUSE = cause_q;

endmodule

// File: tb/tb_mioc_reset_seq.sv
// Testbench for mioc_reset_seq: directed scenarios plus random request
// traffic, compared every cycle against a timeline-based reference model.
module tb_mioc_reset_seq;

  localparam int DB  = 8;
  localparam int RST = 16;
  localparam int NET = 32;

  logic       B_PHI;
  logic       POR_N;
  logic       PBRST_N;
  logic       N_CVRST;
  logic       RST_N;
  logic       CPRST_N;
  logic       NETRST_N;
  logic [1:0] RST_CAUSE;

  int n_checks;
  int n_errors;

  mioc_reset_seq #(
    .DEBOUNCE_CYCLES(DB),
    .RST_STRETCH    (RST),
    .NET_STRETCH    (NET),
    .CNT_W          (16)
  ) dut (
    .B_PHI    (B_PHI),
    .POR_N    (POR_N),
    .PBRST_N  (PBRST_N),
    .N_CVRST  (N_CVRST),
    .RST_N    (RST_N),
    .CPRST_N  (CPRST_N),
    .NETRST_N (NETRST_N),
    .RST_CAUSE(RST_CAUSE)
  );

  initial B_PHI = 1'b0;
  always #5 B_PHI = ~B_PHI;

  // Reference model: reset described as remaining-time budgets
  bit       m_pb_p1, m_pb_p2, m_cv_p1, m_cv_p2;
  bit       m_pb_db;
  int       m_db_run;
  bit       m_rst_active;   // RST_N being held low
  int       m_stretch_left; // cycles of minimum stretch still owed
  int       m_net_left;     // cycles of AdamNET tail still owed
  bit       m_keep_net;     // game reset that interrupted an AdamNET tail
  bit [1:0] m_cause;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pb_p1 = 1'b1; m_pb_p2 = 1'b1; m_cv_p1 = 1'b1; m_cv_p2 = 1'b1;
    m_pb_db = 1'b1; m_db_run = 0;
    m_rst_active = 1'b1; m_stretch_left = RST; m_net_left = 0;
    m_keep_net = 1'b0; m_cause = 2'b01;
  endtask

  task automatic model_start(input bit [1:0] c, input bit k);
    m_rst_active   = 1'b1;
    m_stretch_left = RST;
    m_net_left     = 0;
    m_cause        = c;
    m_keep_net     = k;
  endtask

  task automatic model_step();
    bit pbr, cvr;
    if (!POR_N) begin
      model_reset();
    end else begin
      pbr = !m_pb_db;
      cvr = !m_cv_p2;
      if (m_rst_active) begin
        if (m_cause == 2'b11 && pbr) begin
          m_cause = 2'b10; m_stretch_left = RST; m_keep_net = 1'b0;
        end else begin
          if (m_stretch_left > 0) m_stretch_left--;
          if (m_stretch_left == 0 && !pbr && !cvr) begin
            m_rst_active = 1'b0;
            if (m_cause != 2'b11 || m_keep_net) m_net_left = NET;
          end
        end
      end else if (m_net_left > 0) begin
        if (pbr) model_start(2'b10, 1'b0);
        else if (cvr) model_start(2'b11, 1'b1);
        else begin
          m_net_left--;
          if (m_net_left == 0) m_keep_net = 1'b0;
        end
      end else begin
        if (pbr) model_start(2'b10, 1'b0);
        else if (cvr) model_start(2'b11, 1'b0);
      end
      if (m_pb_p2 == m_pb_db) m_db_run = 0;
      else begin
        m_db_run++;
        if (m_db_run == DB) begin m_pb_db = m_pb_p2; m_db_run = 0; end
      end
      m_pb_p2 = m_pb_p1; m_pb_p1 = PBRST_N;
      m_cv_p2 = m_cv_p1; m_cv_p1 = N_CVRST;
    end
  endtask

  task automatic compare_all();
    bit e_rst, e_cp, e_net;
    e_rst = !m_rst_active;
    e_cp  = !(m_rst_active && m_cause != 2'b11);
    e_net = !((m_rst_active && (m_cause != 2'b11 || m_keep_net)) || m_net_left > 0);
    check_val("RST_N", {31'd0, RST_N}, {31'd0, e_rst});
    check_val("CPRST_N", {31'd0, CPRST_N}, {31'd0, e_cp});
    check_val("NETRST_N", {31'd0, NETRST_N}, {31'd0, e_net});
    check_val("RST_CAUSE", {30'd0, RST_CAUSE}, {30'd0, m_cause});
  endtask

  // One clock: model advances on the rising edge, outputs compared on the falling edge
  task automatic step();
    @(posedge B_PHI);
    model_step();
    @(negedge B_PHI);
    compare_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Power-on reset applied mid-cycle; outputs must react without a clock edge
  task automatic por_pulse(input int n);
    #2;
    POR_N = 1'b0;
    #1;
    check_val("POR_async_RST_N", {31'd0, RST_N}, 32'd0);
    check_val("POR_async_CPRST_N", {31'd0, CPRST_N}, 32'd0);
    check_val("POR_async_NETRST_N", {31'd0, NETRST_N}, 32'd0);
    check_val("POR_async_CAUSE", {30'd0, RST_CAUSE}, 32'd1);
    model_reset();
    run(n);
    POR_N = 1'b1;
  endtask

  initial begin
    int kind;
    n_checks = 0;
    n_errors = 0;
    PBRST_N  = 1'b1;
    N_CVRST  = 1'b1;
    POR_N    = 1'b1;
    #1;
    POR_N = 1'b0;
    #1;
    check_val("reset_RST_N", {31'd0, RST_N}, 32'd0);
    check_val("reset_NETRST_N", {31'd0, NETRST_N}, 32'd0);
    check_val("reset_CAUSE", {30'd0, RST_CAUSE}, 32'd1);
    model_reset();
    run(3);

    // 1: power-on sequence
    POR_N = 1'b1;
    run(60);

    // 2: one-cycle game reset
    N_CVRST = 1'b0; run(1); N_CVRST = 1'b1;
    run(30);

    // 3: bouncing pushbutton, then a solid press
    for (int b = 0; b < 4; b++) begin
      PBRST_N = 1'b0; run(3);
      PBRST_N = 1'b1; run(2);
    end
    PBRST_N = 1'b0; run(40);
    PBRST_N = 1'b1; run(70);

    // 4: both requests together
    PBRST_N = 1'b0; N_CVRST = 1'b0; run(30);
    PBRST_N = 1'b1; N_CVRST = 1'b1; run(70);

    // 5: game reset during the AdamNET tail
    PBRST_N = 1'b0; run(12);
    PBRST_N = 1'b1; run(20);
    N_CVRST = 1'b0; run(1); N_CVRST = 1'b1;
    run(80);

    // 6: power-on reset during the AdamNET tail
    PBRST_N = 1'b0; run(12);
    PBRST_N = 1'b1; run(25);
    por_pulse(3);
    run(60);

    // Random traffic
    for (int s = 0; s < 60; s++) begin
      kind = $urandom_range(0, 6);
      case (kind)
        0: begin N_CVRST = 1'b0; run($urandom_range(1, 3)); N_CVRST = 1'b1; end
        1: begin PBRST_N = 1'b0; run($urandom_range(1, 50)); PBRST_N = 1'b1; end
        2: begin
          PBRST_N = 1'b0; N_CVRST = 1'b0; run($urandom_range(1, 40));
          PBRST_N = 1'b1; N_CVRST = 1'b1;
        end
        3: run($urandom_range(1, 80));
        4: begin
          for (int b = 0; b < 6; b++) begin
            PBRST_N = ~PBRST_N; run($urandom_range(1, 9));
          end
          PBRST_N = 1'b1;
        end
        5: begin
          N_CVRST = 1'b0; run($urandom_range(1, 30));
          PBRST_N = 1'b0; run($urandom_range(1, 30));
          N_CVRST = 1'b1; PBRST_N = 1'b1;
        end
        default: begin run($urandom_range(0, 40)); por_pulse($urandom_range(1, 4)); end
      endcase
      run($urandom_range(0, 60));
    end
    run(100);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
